// File: rtl/prog_loader.sv
// Program-store loader: streams 16 bytes into a 16x8 store and holds the CPU until a load completes.
// Optional checksum byte check is compiled in with `define PROG_CHECKSUM_EN.
module prog_loader (
    input  logic       CK,
    input  logic       RST_N,
    input  logic       LOAD_REQ,
    input  logic [7:0] DIN,
    input  logic       DIN_VLD,
    output logic       DIN_RDY,
    input  logic [3:0] AD,
    output logic [7:0] Q,
    output logic       CPU_HOLD,
    output logic       DONE,
    output logic       ERR,
    output logic [2:0] STATE_DBG
);

`ifdef PROG_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0, LOAD = 3'd1, CHK = 3'd2, RUN = 3'd3, FAIL = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0, LOAD = 3'd1, RUN = 3'd3
    } state_t;
`endif

    state_t     state, next_state;
    logic [3:0] wptr;
    logic [7:0] store [16];
    logic       done_r;
    logic       accept;
    logic       enter_load;
`ifdef PROG_CHECKSUM_EN
    logic [7:0] acc;
`endif

    // Handshake: a byte transfers on a rising edge where DIN_VLD and DIN_RDY are both 1.
    assign accept     = DIN_VLD && DIN_RDY;
    assign enter_load = (next_state == LOAD) && (state != LOAD);

    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        DIN_RDY    = 1'b0;
        case (state)
            IDLE: if (LOAD_REQ) next_state = LOAD;
            LOAD: begin
                DIN_RDY = 1'b1;
                if (accept && wptr == 4'd15) begin
`ifdef PROG_CHECKSUM_EN
                    next_state = CHK;
`else
                    next_state = RUN;
`endif
                end
            end
`ifdef PROG_CHECKSUM_EN
            CHK: begin
                DIN_RDY = 1'b1;
                if (accept) next_state = (DIN == acc) ? RUN : FAIL;
            end
            FAIL: if (LOAD_REQ) next_state = LOAD;
`endif
            RUN:  if (LOAD_REQ) next_state = LOAD;
            default: next_state = IDLE;
        endcase
    end

    // Write pointer wraps from 15 to 0 on the last byte; the FSM has already left LOAD by then.
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            wptr <= 4'd0;
        end else if (enter_load) begin
            wptr <= 4'd0;
        end else if (state == LOAD && accept) begin
            wptr <= wptr + 4'd1;
        end
    end

`ifdef PROG_CHECKSUM_EN
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            acc <= 8'h00;
        end else if (enter_load) begin
            acc <= 8'h00;
        end else if (state == LOAD && accept) begin
            acc <= acc + DIN;
        end
    end
`endif

    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 16; i++) store[i] <= 8'h00;
        end else if (state == LOAD && accept) begin
            store[wptr] <= DIN;
        end
    end

    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) done_r <= 1'b0;
        else        done_r <= (next_state == RUN) && (state != RUN);
    end

    assign Q         = store[AD];
    assign CPU_HOLD  = (state != RUN);
    assign DONE      = done_r;
    assign STATE_DBG = state;
`ifdef PROG_CHECKSUM_EN
    assign ERR = (state == FAIL);
`else
    assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader; a byte-level store model tracks expected Q.
module tb_prog_loader;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_RUN  = 3'd3;
`ifdef PROG_CHECKSUM_EN
    localparam logic [2:0] ST_CHK  = 3'd2;
    localparam logic [2:0] ST_FAIL = 3'd4;
`endif

    logic       CK;
    logic       RST_N;
    logic       LOAD_REQ;
    logic [7:0] DIN;
    logic       DIN_VLD;
    logic       DIN_RDY;
    logic [3:0] AD;
    logic [7:0] Q;
    logic       CPU_HOLD;
    logic       DONE;
    logic       ERR;
    logic [2:0] STATE_DBG;

    int         checks;
    int         failures;
    logic [7:0] prog [16];
    logic [7:0] mem  [16];

    prog_loader dut (
        .CK(CK), .RST_N(RST_N), .LOAD_REQ(LOAD_REQ), .DIN(DIN), .DIN_VLD(DIN_VLD),
        .DIN_RDY(DIN_RDY), .AD(AD), .Q(Q), .CPU_HOLD(CPU_HOLD), .DONE(DONE),
        .ERR(ERR), .STATE_DBG(STATE_DBG)
    );

    initial begin
        CK = 1'b0;
        forever #5 CK = ~CK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic set_stream1();
        prog[0] = 8'h30; prog[1] = 8'h11; prog[2] = 8'hC1; prog[3] = 8'hB3; prog[4] = 8'hB4;
        for (int i = 5; i < 16; i++) prog[i] = 8'h3C;
    endtask

    task automatic set_fill(input logic [7:0] v);
        for (int i = 0; i < 16; i++) prog[i] = v;
    endtask

    task automatic start_load();
        LOAD_REQ = 1'b1;
        tick();
        LOAD_REQ = 1'b0;
        chk("start_state", STATE_DBG, ST_LOAD);
        chk("start_rdy", DIN_RDY, 1'b1);
        chk("start_err", ERR, 1'b0);
    endtask

    // Each byte is fetched at its own address so Q is checked just before and after its write edge.
    task automatic load_program(input bit gap, input bit bad_sum);
        logic [7:0] sum;
        logic       exp_last;
        sum = 8'h00;
        for (int i = 0; i < 16; i++) begin
            AD      = i[3:0];
            DIN     = prog[i];
            DIN_VLD = 1'b1;
            #1;
            chk("q_before_wr", Q, mem[i]);
            tick();
            DIN_VLD = 1'b0;
            mem[i]  = prog[i];
            sum     = sum + prog[i];
            chk("q_after_wr", Q, mem[i]);
`ifdef PROG_CHECKSUM_EN
            exp_last = 1'b0;
`else
            exp_last = (i == 15);
`endif
            chk("done_during_load", DONE, exp_last);
            chk("hold_during_load", CPU_HOLD, !exp_last);
            if (gap && i != 15) begin
                tick();
                chk("stall_rdy", DIN_RDY, 1'b1);
                chk("stall_state", STATE_DBG, ST_LOAD);
                chk("stall_done", DONE, 1'b0);
            end
        end
`ifdef PROG_CHECKSUM_EN
        chk("chk_state", STATE_DBG, ST_CHK);
        chk("chk_rdy", DIN_RDY, 1'b1);
        DIN     = bad_sum ? sum + 8'h01 : sum;
        DIN_VLD = 1'b1;
        tick();
        DIN_VLD = 1'b0;
        chk("chk_done", DONE, !bad_sum);
        chk("chk_err", ERR, bad_sum);
        chk("chk_result_state", STATE_DBG, bad_sum ? ST_FAIL : ST_RUN);
        chk("chk_hold", CPU_HOLD, bad_sum);
`else
        chk("end_sum_unused", bad_sum, 1'b0);
`endif
        tick();
        chk("done_one_cycle", DONE, 1'b0);
        chk("hold_after_load", CPU_HOLD, bad_sum);
    endtask

    task automatic check_store(input string tag);
        for (int a = 0; a < 16; a++) begin
            AD = a[3:0];
            #1;
            chk(tag, Q, mem[a]);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        RST_N    = 1'b0;
        LOAD_REQ = 1'b0;
        DIN      = 8'h00;
        DIN_VLD  = 1'b0;
        AD       = 4'd5;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        #12;
        chk("rst_state", STATE_DBG, ST_IDLE);
        chk("rst_rdy", DIN_RDY, 1'b0);
        chk("rst_hold", CPU_HOLD, 1'b1);
        chk("rst_done", DONE, 1'b0);
        chk("rst_err", ERR, 1'b0);
        chk("rst_q", Q, 8'h00);
        RST_N = 1'b1;
        tick();
        tick();
        chk("post_rst_idle", STATE_DBG, ST_IDLE);
        chk("post_rst_hold", CPU_HOLD, 1'b1);

        // Basic load of the reference stream.
        set_stream1();
        start_load();
        load_program(1'b0, 1'b0);
        check_store("stream1_store");
        AD = 4'd2;  #1; chk("stream1_q2", Q, 8'hC1);
        AD = 4'd15; #1; chk("stream1_q15", Q, 8'h3C);
        AD = 4'd0;  #1; chk("stream1_q0", Q, 8'h30);

        // Reload from RUN; LOAD_REQ held into LOAD must be ignored.
        LOAD_REQ = 1'b1;
        tick();
        chk("reload_hold", CPU_HOLD, 1'b1);
        chk("reload_state", STATE_DBG, ST_LOAD);
        tick();
        chk("load_req_ignored", STATE_DBG, ST_LOAD);
        LOAD_REQ = 1'b0;
        set_fill(8'hA5);
        load_program(1'b0, 1'b0);
        for (int a = 0; a < 16; a++) begin
            AD = a[3:0];
            #1;
            chk("a5_store", Q, 8'hA5);
        end

        // Same reference stream with DIN_VLD toggling every cycle.
        set_stream1();
        start_load();
        load_program(1'b1, 1'b0);
        check_store("gap_store");
        AD = 4'd2; #1; chk("gap_q2", Q, 8'hC1);

`ifdef PROG_CHECKSUM_EN
        set_fill(8'h10);
        start_load();
        load_program(1'b0, 1'b0);
        chk("good_sum_err", ERR, 1'b0);
        start_load();
        load_program(1'b0, 1'b1);
        chk("fail_err_sticky", ERR, 1'b1);
        chk("fail_state_sticky", STATE_DBG, ST_FAIL);
        start_load();
        chk("fail_reload_err", ERR, 1'b0);
        chk("fail_reload_rdy", DIN_RDY, 1'b1);
`else
        start_load();
`endif

        // Reset mid-load after 7 bytes: store must clear and CPU stays held.
        set_stream1();
        for (int i = 0; i < 7; i++) begin
            DIN     = prog[i];
            DIN_VLD = 1'b1;
            tick();
            mem[i]  = prog[i];
        end
        DIN_VLD = 1'b0;
        AD = 4'd1; #1; chk("partial_q1", Q, 8'h11);
        RST_N = 1'b0;
        #2;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        check_store("midrst_store");
        chk("midrst_state", STATE_DBG, ST_IDLE);
        chk("midrst_rdy", DIN_RDY, 1'b0);
        chk("midrst_hold", CPU_HOLD, 1'b1);
        chk("midrst_done", DONE, 1'b0);
        RST_N = 1'b1;
        tick();
        tick();
        chk("after_midrst_idle", STATE_DBG, ST_IDLE);
        chk("after_midrst_hold", CPU_HOLD, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have port CK, input, 1 bit: single system clock; all state changes on rising edge.
REQ-002 The block SHALL have port RST_N, input, 1 bit: reset, asynchronous assert, active-low.
REQ-003 The block SHALL have port LOAD_REQ, input, 1 bit: request to (re)load the program store; level-sampled.
REQ-004 The block SHALL have port DIN, input, 8 bits: program byte, {OP[7:4], IM[3:0]}.
REQ-005 The block SHALL have port DIN_VLD, input, 1 bit: DIN holds a valid byte.
REQ-006 The block SHALL have port DIN_RDY, output, 1 bit: loader can accept a byte this cycle.
REQ-007 The block SHALL have port AD, input, 4 bits: fetch address from the program counter.
REQ-008 The block SHALL have port Q, output, 8 bits: instruction word at AD, to opcode/immediate split.
REQ-009 The block SHALL have port CPU_HOLD, output, 1 bit: high = CPU must not advance (PC/registers frozen).
REQ-010 The block SHALL have port DONE, output, 1 bit: one-cycle pulse when a load completes successfully.
REQ-011 The block SHALL have port ERR, output, 1 bit: checksum failure, sticky until the next load.

Function
REQ-012 The block SHALL implement a 16 x 8 program store; Q SHALL equal store[AD] combinationally (zero-cycle read).
REQ-013 The block SHALL implement the FSM states IDLE, LOAD, CHK, RUN and FAIL.
REQ-014 In IDLE, LOAD_REQ=1 SHALL cause IDLE->LOAD on the next edge; otherwise the FSM SHALL stay in IDLE.
REQ-015 DIN_RDY SHALL be 1 only in LOAD and CHK; a byte SHALL be accepted on an edge where DIN_VLD=1 and DIN_RDY=1.
REQ-016 In LOAD, each accepted byte SHALL be written to store[WPTR], and the 4-bit WPTR SHALL then increment; WPTR SHALL be cleared to 0 on every entry to LOAD.
REQ-017 Acceptance of the byte at WPTR=15 SHALL end LOAD; WPTR SHALL wrap to 0 and SHALL NOT overwrite store[0].
REQ-018 With the checksum compiled out, the FSM SHALL go LOAD->RUN on that edge; with it compiled in, LOAD->CHK.
REQ-019 A cycle with DIN_VLD=0 SHALL stall LOAD/CHK indefinitely, with no timeout and no state change.
REQ-020 LOAD_REQ SHALL be ignored in LOAD and CHK.
REQ-021 In RUN and FAIL, LOAD_REQ=1 SHALL cause a transition to LOAD on the next edge.
REQ-022 CPU_HOLD SHALL be 0 only in RUN.
REQ-023 CPU_HOLD SHALL rise in the same cycle the FSM leaves RUN.
REQ-024 DONE SHALL be 1 for exactly the first cycle in RUN after a load; it SHALL NOT pulse on a repeated LOAD_REQ.
REQ-025 Simultaneous write and fetch to the same address: Q SHALL show the old word until the write edge and the new word after it.
REQ-026 The store SHALL be written only by the LOAD path; there is no other write port.

Reset
REQ-027 While RST_N=0: FSM=IDLE, WPTR=0, checksum accumulator=0, all 16 store words=8'h00.
REQ-028 While RST_N=0: DIN_RDY=0, CPU_HOLD=1, DONE=0, ERR=0, and Q=8'h00.
REQ-029 Reset asserted mid-load SHALL abort the load and discard any partial program; the store SHALL be fully cleared.
REQ-030 After RST_N deasserts, the CPU SHALL remain held until a complete, valid load has been performed.

Configuration
REQ-031 Macro PROG_CHECKSUM_EN SHALL select whether the checksum feature is compiled in.
REQ-032 With PROG_CHECKSUM_EN defined, the accumulator SHALL hold the 8-bit modulo-256 sum of the 16 accepted program bytes.
REQ-033 With PROG_CHECKSUM_EN defined, the 17th byte (accepted in CHK) SHALL be compared with the accumulator: equal -> RUN (DONE pulse); unequal -> FAIL (ERR=1, CPU_HOLD=1, DONE=0).
REQ-034 With PROG_CHECKSUM_EN defined, ERR SHALL clear on entry to LOAD.
REQ-035 With PROG_CHECKSUM_EN undefined, the CHK and FAIL states SHALL be absent, ERR SHALL be tied to 0, and 16 bytes SHALL complete a load.

Verification
REQ-036 Reset then LOAD_REQ and stream 30,11,C1,B3,B4,3C x11 (no checksum) -> DONE pulse once; CPU_HOLD falls; AD=2 gives Q=C1; AD=15 gives Q=3C.
REQ-037 Same stream with DIN_VLD toggled 1/0 every cycle -> identical store contents; DONE pulses after the 16th accepted byte only.
REQ-038 PROG_CHECKSUM_EN, 16 x 8'h10 then 8'h00 -> RUN, DONE=1, ERR=0.
REQ-039 PROG_CHECKSUM_EN, 16 x 8'h10 then 8'h01 -> FAIL, ERR=1, CPU_HOLD=1; a following LOAD_REQ clears ERR and sets DIN_RDY=1.
REQ-040 RST_N pulsed low after the 7th byte -> all Q=00, CPU_HOLD=1, FSM in IDLE, DIN_RDY=0.
REQ-041 In RUN, LOAD_REQ=1 for 1 cycle -> CPU_HOLD=1 next cycle; reload of 16 x 8'hA5 -> Q=A5 at every AD.
